// File: rtl/motor_ramp_sequencer.sv
// Per-motor speed sequencer: ramps PWM duty toward a commanded target on a slow tick,
// handles direction reversals through decel + coast dead-time, and honours emergency stop.
module motor_ramp_sequencer #(
    parameter int MAX_DUTY       = 127,
    parameter int STEP           = 4,
    parameter int TICK_CYCLES    = 128,
    parameter int DEADTIME_TICKS = 2
) (
    input  logic       clk_3125KHz,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_duty,
    input  logic       cmd_dir,
    input  logic       estop,
    output logic [7:0] pulse_width,
    output logic       in_a,
    output logic       in_b,
    output logic       at_speed,
    output logic       busy
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DEADTIME_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD,
        S_REVERSE,
        S_DEAD,
        S_ESTOP
    } state_t;

    state_t          r_state;
    logic [7:0]      r_duty;
    logic [7:0]      r_tgt;
    logic            r_dir;
    logic            r_pend_dir;
    logic [TW-1:0]   r_tick_cnt;
    logic [DW-1:0]   r_dead_cnt;
    logic            r_in_a;
    logic            r_in_b;
    logic            r_at_speed;
    logic            r_busy;

    state_t          w_state_nx;
    logic [7:0]      w_duty_nx;
    logic [7:0]      w_tgt_nx;
    logic            w_dir_nx;
    logic            w_pend_nx;
    logic [DW-1:0]   w_dead_nx;
    logic [7:0]      w_clamped;
    logic [7:0]      w_stepped;
    logic [7:0]      w_decayed;
    logic            w_tick;
    logic            w_drive;

    function automatic logic [7:0] clamp_duty(input logic [7:0] req);
        return (req > 8'(MAX_DUTY)) ? 8'(MAX_DUTY) : req;
    endfunction

    // One ramp step toward tgt, done in 9 bits so neither direction can wrap.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] w_sum;
        w_sum = {1'b0, cur} + 9'(STEP);
        if (cur < tgt)
            return (w_sum > {1'b0, tgt}) ? tgt : w_sum[7:0];
        else if (cur > tgt)
            return ({1'b0, cur} >= ({1'b0, tgt} + 9'(STEP))) ? (cur - 8'(STEP)) : tgt;
        else
            return cur;
    endfunction

    assign w_tick    = (r_tick_cnt == TW'(TICK_CYCLES - 1));
    assign w_clamped = clamp_duty(cmd_duty);
    assign w_stepped = ramp_toward(r_duty, r_tgt);
    assign w_decayed = ramp_toward(r_duty, 8'd0);

    assign cmd_ready = ((r_state == S_IDLE) || (r_state == S_RAMP) || (r_state == S_HOLD)) && !estop;

    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_tgt_nx   = r_tgt;
        w_dir_nx   = r_dir;
        w_pend_nx  = r_pend_dir;
        w_dead_nx  = r_dead_cnt;
        if (estop) begin
            w_state_nx = S_ESTOP;
            w_duty_nx  = 8'd0;
            w_tgt_nx   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_RAMP, S_HOLD: begin
                    // An accepted command takes priority over a coincident tick.
                    if (cmd_valid) begin
                        w_tgt_nx = w_clamped;
                        if (w_clamped == 8'd0) begin
                            w_state_nx = (r_duty == 8'd0) ? S_IDLE : S_RAMP;
                        end else begin
                            w_pend_nx = cmd_dir;
                            if (r_duty == 8'd0) begin
                                w_dir_nx   = cmd_dir;
                                w_state_nx = S_RAMP;
                            end else if (cmd_dir != r_dir) begin
                                w_state_nx = S_REVERSE;
                            end else begin
                                w_state_nx = S_RAMP;
                            end
                        end
                    end else if ((r_state == S_RAMP) && w_tick) begin
                        w_duty_nx = w_stepped;
                        if (w_stepped == r_tgt)
                            w_state_nx = (r_tgt != 8'd0) ? S_HOLD : S_IDLE;
                    end
                end
                S_REVERSE: begin
                    if (w_tick) begin
                        w_duty_nx = w_decayed;
                        if (w_decayed == 8'd0) begin
                            w_state_nx = S_DEAD;
                            w_dead_nx  = '0;
                        end
                    end
                end
                S_DEAD: begin
                    if (w_tick) begin
                        if (r_dead_cnt == DW'(DEADTIME_TICKS - 1)) begin
                            w_dir_nx   = r_pend_dir;
                            w_state_nx = S_RAMP;
                        end else begin
                            w_dead_nx = r_dead_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_duty_nx  = 8'd0;
                end
            endcase
        end
    end

    assign w_drive = (w_state_nx == S_RAMP) || (w_state_nx == S_HOLD) || (w_state_nx == S_REVERSE);

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_duty     <= 8'd0;
            r_tgt      <= 8'd0;
            r_dir      <= 1'b1;
            r_pend_dir <= 1'b1;
            r_tick_cnt <= '0;
            r_dead_cnt <= '0;
            r_in_a     <= 1'b0;
            r_in_b     <= 1'b0;
            r_at_speed <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_duty     <= w_duty_nx;
            r_tgt      <= w_tgt_nx;
            r_dir      <= w_dir_nx;
            r_pend_dir <= w_pend_nx;
            r_dead_cnt <= w_dead_nx;
            // Tick counter free-runs; only ESTOP (and reset) pins it at zero.
            if (estop || (r_state == S_ESTOP) || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;
            r_in_a     <= w_drive & w_dir_nx;
            r_in_b     <= w_drive & ~w_dir_nx;
            r_at_speed <= (w_state_nx == S_HOLD);
            r_busy     <= (w_state_nx != S_IDLE);
        end
    end

    assign pulse_width = r_duty;
    assign in_a        = r_in_a;
    assign in_b        = r_in_b;
    assign at_speed    = r_at_speed;
    assign busy        = r_busy;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: ramp, saturation, reversal, retarget, estop, reset.
`timescale 1ns/1ps
module tb_motor_ramp_sequencer;

    logic       clk_3125KHz = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_duty;
    logic       cmd_dir;
    logic       estop;
    logic [7:0] pulse_width;
    logic       in_a;
    logic       in_b;
    logic       at_speed;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int n;

    localparam int WAIT_LIMIT = 400;

    motor_ramp_sequencer #(
        .MAX_DUTY(127), .STEP(4), .TICK_CYCLES(128), .DEADTIME_TICKS(2)
    ) dut (
        .clk_3125KHz(clk_3125KHz),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_duty   (cmd_duty),
        .cmd_dir    (cmd_dir),
        .estop      (estop),
        .pulse_width(pulse_width),
        .in_a       (in_a),
        .in_b       (in_b),
        .at_speed   (at_speed),
        .busy       (busy)
    );

    always #5 clk_3125KHz = ~clk_3125KHz;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pw", pulse_width, 0);
        check("rst_bridge", {in_a, in_b}, 0);
        check("rst_at_speed", at_speed, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk_3125KHz);
        rst_n = 1'b1;
        #1;
        check("rst_ready", cmd_ready, 1);
    endtask

    task automatic send(input int duty, input logic dir);
        cmd_valid = 1'b1;
        cmd_duty  = 8'(duty);
        cmd_dir   = dir;
        @(negedge clk_3125KHz);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for any change of duty or bridge; returns cycles waited.
    task automatic wait_change(output int cyc);
        logic [9:0] old;
        old = {pulse_width, in_a, in_b};
        cyc = 0;
        while (({pulse_width, in_a, in_b} == old) && (cyc < WAIT_LIMIT)) begin
            @(negedge clk_3125KHz);
            cyc++;
        end
        check("wait_bound", int'(cyc < WAIT_LIMIT), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0;
        cmd_duty  = 8'd0;
        cmd_dir   = 1'b1;
        estop     = 1'b0;

        // Accelerate from reset to 100 forward
        do_reset();
        send(100, 1'b1);
        check("acc_bridge0", {in_a, in_b}, 2);
        check("acc_busy0", busy, 1);
        check("acc_pw0", pulse_width, 0);
        for (int k = 1; k <= 25; k++) begin
            wait_change(n);
            check("acc_pw", pulse_width, 4 * k);
            check("acc_gap", n, (k == 1) ? 127 : 128);
        end
        check("acc_at_speed", at_speed, 1);
        check("acc_busy", busy, 1);
        repeat (300) @(negedge clk_3125KHz);
        check("acc_hold_pw", pulse_width, 100);

        // Saturation at MAX_DUTY
        do_reset();
        send(200, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            wait_change(n);
            check("sat_pw", pulse_width, (k < 32) ? 4 * k : 127);
        end
        check("sat_at_speed", at_speed, 1);
        repeat (400) @(negedge clk_3125KHz);
        check("sat_hold_pw", pulse_width, 127);

        // Reversal 40 forward -> 20 reverse
        do_reset();
        send(40, 1'b1);
        for (int k = 1; k <= 10; k++) wait_change(n);
        check("rev_start_pw", pulse_width, 40);
        check("rev_start_at_speed", at_speed, 1);
        send(20, 1'b0);
        check("rev_ready", cmd_ready, 0);
        check("rev_bridge_hold", {in_a, in_b}, 2);
        check("rev_pw_hold", pulse_width, 40);
        check("rev_at_speed", at_speed, 0);
        for (int k = 1; k <= 10; k++) begin
            wait_change(n);
            check("rev_down_pw", pulse_width, 40 - 4 * k);
            check("rev_down_bridge", {in_a, in_b}, (k < 10) ? 2 : 0);
            check("rev_down_gap", n, (k == 1) ? 127 : 128);
        end
        wait_change(n);
        check("rev_dead_len", n, 256);
        check("rev_new_bridge", {in_a, in_b}, 1);
        check("rev_new_pw", pulse_width, 0);
        for (int k = 1; k <= 5; k++) begin
            wait_change(n);
            check("rev_up_pw", pulse_width, 4 * k);
            check("rev_up_bridge", {in_a, in_b}, 1);
        end
        check("rev_at_speed_end", at_speed, 1);
        check("rev_ready_end", cmd_ready, 1);

        // Retarget mid-ramp then stop
        do_reset();
        send(100, 1'b1);
        for (int k = 1; k <= 12; k++) wait_change(n);
        check("rt_start_pw", pulse_width, 48);
        send(10, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            wait_change(n);
            check("rt_pw", pulse_width, (k < 10) ? 48 - 4 * k : 10);
        end
        check("rt_at_speed", at_speed, 1);
        send(0, 1'b1);
        check("stop_busy0", busy, 1);
        check("stop_bridge0", {in_a, in_b}, 2);
        for (int k = 1; k <= 3; k++) begin
            wait_change(n);
            check("stop_pw", pulse_width, (k < 3) ? 10 - 4 * k : 0);
        end
        check("stop_bridge", {in_a, in_b}, 0);
        check("stop_busy", busy, 0);
        check("stop_at_speed", at_speed, 0);
        check("stop_ready", cmd_ready, 1);

        // Emergency stop mid-ramp with a command pending
        do_reset();
        send(100, 1'b1);
        for (int k = 1; k <= 5; k++) wait_change(n);
        check("es_start_pw", pulse_width, 20);
        repeat (10) @(negedge clk_3125KHz);
        cmd_valid = 1'b1;
        cmd_duty  = 8'd60;
        cmd_dir   = 1'b0;
        estop     = 1'b1;
        #1;
        check("es_ready", cmd_ready, 0);
        @(negedge clk_3125KHz);
        check("es_pw", pulse_width, 0);
        check("es_bridge", {in_a, in_b}, 0);
        check("es_busy", busy, 1);
        check("es_at_speed", at_speed, 0);
        repeat (5) @(negedge clk_3125KHz);
        check("es_pw_held", pulse_width, 0);
        estop     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk_3125KHz);
        check("es_exit_busy", busy, 0);
        check("es_exit_ready", cmd_ready, 1);
        check("es_exit_pw", pulse_width, 0);
        send(8, 1'b1);
        check("es_new_bridge", {in_a, in_b}, 2);
        for (int k = 1; k <= 2; k++) begin
            wait_change(n);
            check("es_new_pw", pulse_width, 4 * k);
            check("es_new_gap_ok", int'(n <= 128), 1);
        end
        check("es_new_at_speed", at_speed, 1);

        // Asynchronous reset in the middle of a reversal
        do_reset();
        send(40, 1'b1);
        for (int k = 1; k <= 10; k++) wait_change(n);
        send(20, 1'b0);
        for (int k = 1; k <= 3; k++) wait_change(n);
        check("mr_pw", pulse_width, 28);
        check("mr_bridge", {in_a, in_b}, 2);
        repeat (20) @(negedge clk_3125KHz);
        do_reset();
        check("mr_busy", busy, 0);
        send(12, 1'b1);
        check("mr_fwd_bridge", {in_a, in_b}, 2);
        wait_change(n);
        check("mr_first_pw", pulse_width, 4);
        check("mr_first_gap", n, 127);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_ramp_sequencer.md
# motor_ramp_sequencer

Per-motor speed sequencer that sits upstream of the motor PWM generator and drives its 8-bit `pulse_width` input and the H-bridge direction pins. It accepts speed/direction commands over a valid/ready handshake and ramps duty toward the target in fixed steps on a slow tick. Direction reversals always decelerate to zero and insert a coast dead-time before the new direction is driven. An emergency-stop input overrides everything. One instance per motor.

## Interface
- `MAX_DUTY`, 127: duty saturation ceiling. The PWM generator has a 7-bit, 128-cycle period; 0 is always-low.
- `STEP`, 4: duty change per ramp tick (1..MAX_DUTY).
- `TICK_CYCLES`, 128: clock cycles per ramp tick (≥2).
- `DEADTIME_TICKS`, 2: ramp ticks spent coasting during a reversal (≥1).

Ports:
- `clk_3125KHz` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on a cycle where valid & ready.
- `cmd_duty` in 8: target duty, unsigned.
- `cmd_dir` in 1: 1 = forward, 0 = reverse.
- `estop` in 1: level emergency stop, sampled synchronously.
- `pulse_width` out 8: to the PWM generator.
- `in_a`, `in_b` out 1 each: H-bridge inputs. 10 = forward, 01 = reverse, 00 = coast. 11 is never driven.
- `at_speed` out 1: duty equals a nonzero target, state HOLD.
- `busy` out 1: state ≠ IDLE.

## Operation
- **Tick.** A free-running counter counts 0..TICK_CYCLES-1 and wraps. `tick` is asserted when count = TICK_CYCLES-1. The counter is never restarted by commands; only reset and ESTOP clear it.
- **Accept.** `cmd_ready` = (state ∈ {IDLE, RAMP, HOLD}) & !estop. On accept:
  - `tgt` = min(`cmd_duty`, MAX_DUTY).
  - `pend_dir` = `cmd_dir`.
- **Routing after accept.**
  - If `tgt` = 0: `pend_dir` is ignored. If duty = 0, go to IDLE; otherwise go to RAMP.
  - Else if duty = 0: set `dir` = `pend_dir` and go to RAMP.
  - Else if `pend_dir` ≠ `dir`: go to REVERSE.
  - Else: go to RAMP; a new target replaces the old one mid-ramp.
- **IDLE.** duty 0, bridge 00.
- **RAMP.** On tick:
  - If duty < tgt: duty = min(duty+STEP, tgt).
  - If duty > tgt: duty = max(duty-STEP, tgt).
  - When duty reaches tgt: go to HOLD if tgt ≠ 0, else IDLE.
  - All arithmetic is 9-bit with no wrap.
- **HOLD.** Duty stays constant; `at_speed` = 1.
- **REVERSE.** On tick, duty = max(duty-STEP, 0). When duty = 0, go to DEAD with the dead-tick counter cleared.
- **DEAD.** Bridge 00, duty 0. Count DEADTIME_TICKS ticks. Then set `dir` = `pend_dir`, drive the new bridge value, and go to RAMP toward tgt.
- **ESTOP.** Entered from any state on the first cycle `estop` = 1.
  - duty 0, bridge 00, tgt 0, tick counter held at 0.
  - Exit to IDLE on the first cycle `estop` = 0.
- **Bridge outputs.** In IDLE, DEAD and ESTOP the bridge is 00. In RAMP, HOLD and REVERSE it is 10 if `dir` = 1, else 01.
- **Output relation.** `pulse_width` = duty, zero-extended to 8 bits.

## Timing
- **Reset values.** `pulse_width` 0, `in_a`/`in_b` 0, `at_speed` 0, `busy` 0, state IDLE, `dir` 1, tick counter 0.
  - `cmd_ready` is 1 after reset deassertion.
  - Commands are ignored while `rst_n` is low.
- **Register timing.** `pulse_width`, `in_a`/`in_b`, `at_speed` and `busy` are registered and change on the edge that performs the transition.
- **Accept latency.** The state and bridge change on the accept edge. The first duty step occurs at the next tick, 1..TICK_CYCLES cycles later.
- **Bridge/duty ordering.** In REVERSE the bridge stays on the old direction until duty = 0. The bridge is 00 for exactly DEADTIME_TICKS ticks. The new direction is driven on the DEAD→RAMP edge, and duty is still 0 on that edge.
- **ESTOP timing.** `estop` rising forces `pulse_width` = 0 and bridge 00 on the next edge. This overrides a simultaneous accept or tick.
- **Reset mid-operation.** A reset asserted mid-ramp returns all outputs to their reset values immediately (asynchronous). No partial state survives.

## Test plan
- **Accelerate.** From reset, accept duty 100 forward → bridge 10, `pulse_width` 4, 8, … one step per 128 cycles. After 25 ticks it is 100; `at_speed` = 1, `busy` = 1.
- **Saturation.** Accept duty 200 forward → target clamps to 127. After 31 ticks `pulse_width` = 124; the 32nd tick gives 127 and HOLD. It never exceeds 127.
- **Reversal.** At HOLD with duty 40 forward, accept duty 20 reverse:
  - `cmd_ready` goes to 0 and duty falls 36 … 0 over 10 ticks with bridge 10.
  - Bridge is 00 for 2 ticks.
  - Bridge goes to 01 with duty 0, then ramps to 20 in 5 ticks.
- **Retarget and stop.** Mid-ramp at duty 48 toward 100, accept duty 10 same direction → the next ticks give 44, 40, …, 12, 10, then HOLD. Then accept duty 0 → ramp down to 0, IDLE, bridge 00, `busy` = 0.
- **Emergency stop.** Assert `estop` mid-ramp while `cmd_valid` = 1 → `cmd_ready` = 0 and the command is not accepted. Next edge: `pulse_width` 0, bridge 00. Deassert → IDLE; a new command ramps from 0.
- **Reset mid-operation.** Pulse `rst_n` low for 3 cycles during REVERSE → all outputs take their reset values asynchronously. After release, IDLE with `cmd_ready` = 1 and `dir` forward.
